mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single-ported 256×8 program/data RAM of the 8-bit computer. It shares the RAM between the CPU datapath (fetch, MOV, PUSH/POP, CALL/RET) and a DMA/program-loader requester. Each access runs as an IDLE → ACCESS → WAIT → RESP sequence. Sits between both requesters and the RAM, replacing direct c_ri/c_ro/addr_bus wiring to the RAM.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 15 +
 rtl/arb_pick2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit computer's RAM port arbiter.
// Holds the sequencer state encoding, owner codes and parameter range limits.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam int READ_LAT_MIN  = 1;
    localparam int READ_LAT_MAX  = 4;
    localparam int BURST_MAX_MIN = 1;
    localparam int BURST_MAX_MAX = 255;

    function automatic bit params_ok(input int read_lat, input int burst_max);
        return (read_lat >= READ_LAT_MIN) && (read_lat <= READ_LAT_MAX) &&
               (burst_max >= BURST_MAX_MIN) && (burst_max <= BURST_MAX_MAX);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/acknowledge port of one RAM requester (CPU datapath or DMA loader).
// The requester drives the master side, the arbiter implements the slave side.
interface mem_port_arbiter_if;

    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/arb_pick2.sv
// Two-way winner select: a lone requester wins, a held DMA lock keeps the DMA,
// otherwise round-robin hands the grant to whoever was not granted last.
module arb_pick2
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_ok,
    output logic       grant_valid,
    output logic       winner
);

    always_comb begin
        grant_valid = |req;
        winner      = OWNER_CPU;
        case (req)
            2'b01:   winner = OWNER_CPU;
            2'b10:   winner = OWNER_DMA;
            2'b11:   winner = (last == OWNER_DMA && lock_ok) ? OWNER_DMA : ~last;
            default: winner = OWNER_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer sharing the single-ported 256x8 RAM between the CPU and the DMA port.
// Every access walks IDLE -> ACCESS -> (WAIT) -> RESP with fully registered outputs.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int READ_LAT  = 1,
    parameter int BURST_MAX = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  cpu,
    mem_port_arbiter_if.slave  dma,
    input  logic               dma_lock,
    output logic [7:0]         ram_addr,
    output logic               ram_we,
    output logic               ram_re,
    output logic [7:0]         ram_wdata,
    input  logic [7:0]         ram_rdata,
    output logic               busy,
    output logic               owner
);

    localparam logic [1:0] WAIT_LOAD   = 2'(READ_LAT - 1);
    localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

    if (!params_ok(READ_LAT, BURST_MAX)) begin : g_bad_params
        $error("mem_port_arbiter: READ_LAT must be 1..4 and BURST_MAX 1..255");
    end

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       ram_we_q, ram_we_d;
    logic       ram_re_q, ram_re_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic       dma_ack_q, dma_ack_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0] dma_rdata_q, dma_rdata_d;

    logic lock_ok;
    logic grant_valid;
    logic winner;

    assign lock_ok = dma_lock && (burst_cnt_q < BURST_MAX_C);

    arb_pick2 u_pick (
        .req         ({dma.req, cpu.req}),
        .last        (owner_q),
        .lock_ok     (lock_ok),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ACCESS;
                    owner_d = winner;
                    if (winner == OWNER_DMA) begin
                        we_d    = dma.we;
                        addr_d  = dma.addr;
                        wdata_d = dma.wdata;
                        // Only a locked DMA regrant extends the burst; any other DMA grant starts a new one.
                        if (dma_lock && owner_q == OWNER_DMA) begin
                            if (burst_cnt_q < BURST_MAX_C)
                                burst_cnt_d = burst_cnt_q + 8'd1;
                        end else begin
                            burst_cnt_d = 8'd1;
                        end
                    end else begin
                        we_d        = cpu.we;
                        addr_d      = cpu.addr;
                        wdata_d     = cpu.wdata;
                        burst_cnt_d = 8'd0;
                    end
                    ram_we_d = we_d;
                    ram_re_d = !we_d;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d   = RESP;
                    cpu_ack_d = (owner_q == OWNER_CPU);
                    dma_ack_d = (owner_q == OWNER_DMA);
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d   = RESP;
                    cpu_ack_d = (owner_q == OWNER_CPU);
                    dma_ack_d = (owner_q == OWNER_DMA);
                    if (owner_q == OWNER_DMA)
                        dma_rdata_d = ram_rdata;
                    else
                        cpu_rdata_d = ram_rdata;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_DMA;
            we_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            wait_cnt_q  <= 2'd0;
            burst_cnt_q <= 8'd0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign cpu.ack   = cpu_ack_q;
    assign cpu.rdata = cpu_rdata_q;
    assign dma.ack   = dma_ack_q;
    assign dma.rdata = dma_rdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with READ_LAT=1/BURST_MAX=3,
// a second with READ_LAT=3 for long-read and reset-abort behaviour.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter_if a_cpu ();
    mem_port_arbiter_if a_dma ();
    mem_port_arbiter_if b_cpu ();
    mem_port_arbiter_if b_dma ();

    logic       a_dma_lock, b_dma_lock;
    logic [7:0] a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic [7:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic       a_ram_we, a_ram_re, a_busy, a_owner;
    logic       b_ram_we, b_ram_re, b_busy, b_owner;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] b_p0, b_p1;

    mem_port_arbiter #(.READ_LAT(1), .BURST_MAX(3)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .cpu(a_cpu), .dma(a_dma), .dma_lock(a_dma_lock),
        .ram_addr(a_ram_addr), .ram_we(a_ram_we), .ram_re(a_ram_re), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .busy(a_busy), .owner(a_owner)
    );

    mem_port_arbiter #(.READ_LAT(3), .BURST_MAX(8)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .cpu(b_cpu), .dma(b_dma), .dma_lock(b_dma_lock),
        .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_re(b_ram_re), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy), .owner(b_owner)
    );

    // RAM models: preloaded while reset is low, then 1-cycle and 3-cycle read pipelines.
    always @(posedge clk) begin
        if (!reset_n) begin
            mem_a[8'h10] <= 8'hA5;
        end else begin
            if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
            if (a_ram_re) a_ram_rdata <= mem_a[a_ram_addr];
        end
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            mem_b[8'h20] <= 8'h5A;
        end else begin
            if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
            if (b_ram_re) b_p0 <= mem_b[b_ram_addr];
        end
        b_p1        <= b_p0;
        b_ram_rdata <= b_p1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expected);
        n_vec++;
        assert (obs === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, expected);
        end
    endtask

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] expected);
        n_vec++;
        assert (obs === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %02h, expected %02h", tag, obs, expected);
        end
    endtask

    // who: 0 = CPU acked, 1 = DMA acked, 2 = no ack within budget, 3 = both acked
    task automatic wait_a_ack(output int who);
        who = 2;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_cpu.ack || a_dma.ack) begin
                who = (a_cpu.ack && a_dma.ack) ? 3 : (a_dma.ack ? 1 : 0);
                break;
            end
        end
    endtask

    initial begin
        int   who;
        logic any_ack;
        logic exp_alt   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic exp_burst [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        reset_n    = 1'b0;
        a_dma_lock = 1'b0;
        b_dma_lock = 1'b0;
        a_cpu.req = 1'b0; a_cpu.we = 1'b0; a_cpu.addr = 8'h00; a_cpu.wdata = 8'h00;
        a_dma.req = 1'b0; a_dma.we = 1'b0; a_dma.addr = 8'h00; a_dma.wdata = 8'h00;
        b_cpu.req = 1'b0; b_cpu.we = 1'b0; b_cpu.addr = 8'h00; b_cpu.wdata = 8'h00;
        b_dma.req = 1'b0; b_dma.we = 1'b0; b_dma.addr = 8'h00; b_dma.wdata = 8'h00;
        tick();
        tick();

        check_bit("rst_busy", a_busy, 1'b0);
        check_bit("rst_owner", a_owner, 1'b1);
        check_bit("rst_ram_we", a_ram_we, 1'b0);
        check_bit("rst_ram_re", a_ram_re, 1'b0);
        check_output("rst_ram_addr", a_ram_addr, 8'h00);
        check_output("rst_ram_wdata", a_ram_wdata, 8'h00);
        check_bit("rst_cpu_ack", a_cpu.ack, 1'b0);
        check_bit("rst_dma_ack", a_dma.ack, 1'b0);
        check_output("rst_cpu_rdata", a_cpu.rdata, 8'h00);
        check_output("rst_dma_rdata", a_dma.rdata, 8'h00);
        #2 reset_n = 1'b1;

        $display("[TB] CPU read of 0x10, READ_LAT=1");
        a_cpu.req = 1'b1; a_cpu.we = 1'b0; a_cpu.addr = 8'h10;
        tick();
        check_bit("rd_access_re", a_ram_re, 1'b1);
        check_bit("rd_access_we", a_ram_we, 1'b0);
        check_output("rd_access_addr", a_ram_addr, 8'h10);
        check_bit("rd_access_busy", a_busy, 1'b1);
        check_bit("rd_access_owner", a_owner, 1'b0);
        check_bit("rd_access_ack", a_cpu.ack, 1'b0);
        tick();
        check_bit("rd_wait_re", a_ram_re, 1'b0);
        check_output("rd_wait_addr", a_ram_addr, 8'h10);
        check_bit("rd_wait_ack", a_cpu.ack, 1'b0);
        tick();
        check_bit("rd_resp_cpu_ack", a_cpu.ack, 1'b1);
        check_output("rd_resp_cpu_rdata", a_cpu.rdata, 8'hA5);
        check_bit("rd_resp_dma_ack", a_dma.ack, 1'b0);
        a_cpu.req = 1'b0;
        tick();
        check_bit("rd_idle_ack", a_cpu.ack, 1'b0);
        check_bit("rd_idle_busy", a_busy, 1'b0);

        $display("[TB] DMA write of 0x3C to 0x80");
        a_dma.req = 1'b1; a_dma.we = 1'b1; a_dma.addr = 8'h80; a_dma.wdata = 8'h3C;
        tick();
        check_bit("wr_access_we", a_ram_we, 1'b1);
        check_bit("wr_access_re", a_ram_re, 1'b0);
        check_output("wr_access_addr", a_ram_addr, 8'h80);
        check_output("wr_access_wdata", a_ram_wdata, 8'h3C);
        check_bit("wr_access_owner", a_owner, 1'b1);
        tick();
        check_bit("wr_resp_dma_ack", a_dma.ack, 1'b1);
        check_bit("wr_resp_cpu_ack", a_cpu.ack, 1'b0);
        check_bit("wr_resp_we", a_ram_we, 1'b0);
        a_dma.req = 1'b0;
        tick();
        check_output("wr_ram_0x80", mem_a[8'h80], 8'h3C);
        check_output("wr_dma_rdata_kept", a_dma.rdata, 8'h00);
        check_output("wr_cpu_rdata_kept", a_cpu.rdata, 8'hA5);

        $display("[TB] both requesting, no lock: round-robin");
        a_cpu.we = 1'b1; a_cpu.addr = 8'h01; a_cpu.wdata = 8'h11;
        a_dma.we = 1'b1; a_dma.addr = 8'h02; a_dma.wdata = 8'h22;
        a_cpu.req = 1'b1; a_dma.req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_a_ack(who);
            check_output("rr_grant", 8'(who), {7'd0, exp_alt[g]});
            check_bit("rr_owner", a_owner, exp_alt[g]);
            if (g == 3) begin
                a_cpu.req = 1'b0;
                a_dma.req = 1'b0;
            end
        end
        tick();

        $display("[TB] lone CPU write, then locked DMA burst with BURST_MAX=3");
        a_cpu.req = 1'b1;
        wait_a_ack(who);
        check_output("solo_cpu_grant", 8'(who), 8'd0);
        a_cpu.req = 1'b0;
        tick();
        a_dma_lock = 1'b1;
        a_cpu.req  = 1'b1;
        a_dma.req  = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_a_ack(who);
            check_output("burst_grant", 8'(who), {7'd0, exp_burst[g]});
            check_bit("burst_owner", a_owner, exp_burst[g]);
            if (g == 4) begin
                a_cpu.req  = 1'b0;
                a_dma.req  = 1'b0;
                a_dma_lock = 1'b0;
            end
        end

        $display("[TB] READ_LAT=3 read of 0x20");
        b_cpu.req = 1'b1; b_cpu.we = 1'b0; b_cpu.addr = 8'h20;
        tick();
        check_bit("lat3_access_re", b_ram_re, 1'b1);
        check_output("lat3_access_addr", b_ram_addr, 8'h20);
        for (int w = 0; w < 3; w++) begin
            tick();
            check_bit("lat3_wait_re", b_ram_re, 1'b0);
            check_bit("lat3_wait_ack", b_cpu.ack, 1'b0);
            check_bit("lat3_wait_busy", b_busy, 1'b1);
        end
        tick();
        check_bit("lat3_resp_ack", b_cpu.ack, 1'b1);
        check_output("lat3_resp_rdata", b_cpu.rdata, 8'h5A);
        check_bit("lat3_resp_dma_ack", b_dma.ack, 1'b0);
        b_cpu.req = 1'b0;
        tick();
        check_bit("lat3_idle_busy", b_busy, 1'b0);

        $display("[TB] reset pulsed during WAIT");
        b_cpu.req = 1'b1; b_cpu.addr = 8'h21;
        tick();
        check_bit("abort_access_re", b_ram_re, 1'b1);
        check_bit("abort_access_owner", b_owner, 1'b0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check_bit("abort_re", b_ram_re, 1'b0);
        check_bit("abort_we", b_ram_we, 1'b0);
        check_bit("abort_busy", b_busy, 1'b0);
        check_bit("abort_owner", b_owner, 1'b1);
        check_bit("abort_ack", b_cpu.ack, 1'b0);
        check_output("abort_rdata", b_cpu.rdata, 8'h00);
        b_cpu.req = 1'b0;
        #2 reset_n = 1'b1;
        any_ack = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            any_ack = any_ack | b_cpu.ack | b_dma.ack;
        end
        check_bit("abort_no_late_ack", any_ack, 1'b0);
        check_bit("abort_idle_busy", b_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
